grf_wb_arbiter: RTL and testbench

//  Write-side driver for the GRF's single write port (WE/A3/WD3 plus trace PC).

---
 rtl/grf_wb_pkg.sv | 19 +
 rtl/grf_wb_arbiter_if.sv | 34 +++
 rtl/grf_wb_arbiter_wb_fifo.sv | 74 +++++++
 rtl/grf_wb_arbiter.sv | 109 ++++++++++
 tb/tb_grf_wb_arbiter.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/grf_wb_pkg.sv
// Shared widths and payload types for the GRF write-back arbiter and its MDU result FIFO.
package grf_wb_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NREGS  = 1 << REG_AW;

  typedef struct packed {
    logic [REG_AW-1:0] a3;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] pc;
  } wb_req_t;

  typedef struct packed {
    logic    live;
    wb_req_t req;
  } wb_entry_t;

endpackage

// File: rtl/grf_wb_arbiter_if.sv
// W-stage, MDU and GRF write-port signals of the write-back arbiter.
interface grf_wb_arbiter_if #(
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          pipe_we;
  logic [AW-1:0] pipe_a3;
  logic [DW-1:0] pipe_wd;
  logic [DW-1:0] pipe_pc;
  logic          mdu_valid;
  logic          mdu_ready;
  logic [AW-1:0] mdu_a3;
  logic [DW-1:0] mdu_wd;
  logic [DW-1:0] mdu_pc;
  logic          grf_we;
  logic [AW-1:0] grf_a3;
  logic [DW-1:0] grf_wd;
  logic [DW-1:0] grf_pc;
  logic [31:0]   pend_mask;
  logic [CW-1:0] fifo_count;

  modport master (
    output pipe_we, pipe_a3, pipe_wd, pipe_pc, mdu_valid, mdu_a3, mdu_wd, mdu_pc,
    input  mdu_ready, grf_we, grf_a3, grf_wd, grf_pc, pend_mask, fifo_count
  );

  modport slave (
    input  pipe_we, pipe_a3, pipe_wd, pipe_pc, mdu_valid, mdu_a3, mdu_wd, mdu_pc,
    output mdu_ready, grf_we, grf_a3, grf_wd, grf_pc, pend_mask, fifo_count
  );
endinterface

// File: rtl/grf_wb_arbiter_wb_fifo.sv
// Circular MDU result buffer with kill-by-address; exposes the live-register mask of its next state.
module wb_fifo
  import grf_wb_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  wb_entry_t         i_push_entry,
  input  logic              i_pop,
  input  logic              i_kill,
  input  logic [REG_AW-1:0] i_kill_a3,
  output wb_entry_t         o_head,
  output logic [CW-1:0]     o_count,
  output logic              o_empty,
  output logic              o_full,
  output logic [NREGS-1:0]  o_live_mask_nxt
);

  wb_entry_t         r_mem [DEPTH];
  logic [PW-1:0]     r_rd;
  logic [PW-1:0]     r_wr;
  logic [CW-1:0]     r_count;

  wb_entry_t         w_mem [DEPTH];
  logic [PW-1:0]     w_rd;
  logic [PW-1:0]     w_wr;
  logic [CW-1:0]     w_count;
  logic [PW-1:0]     w_off;
  logic [NREGS-1:0]  w_mask;

  // Kill is applied before the push so a same-cycle push survives the pipe write.
  always_comb begin
    w_mem   = r_mem;
    w_off   = '0;
    w_mask  = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (i_kill && (r_mem[i].req.a3 == i_kill_a3)) w_mem[i].live = 1'b0;
    end
    if (i_push) w_mem[r_wr] = i_push_entry;
    w_rd    = r_rd + PW'(i_pop);
    w_wr    = r_wr + PW'(i_push);
    w_count = r_count + CW'(i_push) - CW'(i_pop);
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_off = PW'(i) - w_rd;
      if (({1'b0, w_off} < w_count) && w_mem[i].live) w_mask[w_mem[i].req.a3] = 1'b1;
    end
    w_mask[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= w_mem[i];
      r_rd    <= w_rd;
      r_wr    <= w_wr;
      r_count <= w_count;
    end
  end

  assign o_head          = r_mem[r_rd];
  assign o_count         = r_count;
  assign o_empty         = (r_count == '0);
  assign o_full          = (r_count == CW'(DEPTH));
  assign o_live_mask_nxt = w_mask;

endmodule

// File: rtl/grf_wb_arbiter.sv
// GRF write-port arbiter: W stage has priority, MDU results drain from a FIFO.
// Optional WB_TRACE_EN prints a trace line for every committed write.
module grf_wb_arbiter
  import grf_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = REG_AW,
  parameter int unsigned DW    = DATA_W
) (
  input  logic             clk,
  input  logic             reset,
  grf_wb_arbiter_if.slave  io_wb
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic              w_pipe_commit;
  logic              w_pop;
  logic              w_push;
  logic              w_empty;
  logic              w_full;
  wb_entry_t         w_head;
  wb_entry_t         w_push_entry;
  logic [CW-1:0]     w_count;
  logic [NREGS-1:0]  w_mask_nxt;

  logic              w_we_n;
  logic [AW-1:0]     w_a3_n;
  logic [DW-1:0]     w_wd_n;
  logic [DW-1:0]     w_pc_n;

  logic              r_grf_we;
  logic [AW-1:0]     r_grf_a3;
  logic [DW-1:0]     r_grf_wd;
  logic [DW-1:0]     r_grf_pc;
  logic [31:0]       r_pend_mask;

  // A write to $0 is a no-write: it neither commits nor blocks a pop; an MDU result to $0 is dropped.
  assign w_pipe_commit = io_wb.pipe_we && (io_wb.pipe_a3 != '0);
  assign w_pop         = !w_pipe_commit && !w_empty;
  assign w_push        = io_wb.mdu_valid && io_wb.mdu_ready && (io_wb.mdu_a3 != '0);

  assign w_push_entry.live   = 1'b1;
  assign w_push_entry.req.a3 = REG_AW'(io_wb.mdu_a3);
  assign w_push_entry.req.wd = DATA_W'(io_wb.mdu_wd);
  assign w_push_entry.req.pc = DATA_W'(io_wb.mdu_pc);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk             (clk),
    .reset           (reset),
    .i_push          (w_push),
    .i_push_entry    (w_push_entry),
    .i_pop           (w_pop),
    .i_kill          (w_pipe_commit),
    .i_kill_a3       (REG_AW'(io_wb.pipe_a3)),
    .o_head          (w_head),
    .o_count         (w_count),
    .o_empty         (w_empty),
    .o_full          (w_full),
    .o_live_mask_nxt (w_mask_nxt)
  );

  // Next GRF write: pipe first, else FIFO head (a dead head produces an idle cycle).
  always_comb begin
    w_we_n = 1'b0;
    w_a3_n = '0;
    w_wd_n = '0;
    w_pc_n = '0;
    if (w_pipe_commit) begin
      w_we_n = 1'b1;
      w_a3_n = io_wb.pipe_a3;
      w_wd_n = io_wb.pipe_wd;
      w_pc_n = io_wb.pipe_pc;
    end else if (w_pop && w_head.live) begin
      w_we_n = 1'b1;
      w_a3_n = AW'(w_head.req.a3);
      w_wd_n = DW'(w_head.req.wd);
      w_pc_n = DW'(w_head.req.pc);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_grf_we    <= 1'b0;
      r_grf_a3    <= '0;
      r_grf_wd    <= '0;
      r_grf_pc    <= '0;
      r_pend_mask <= '0;
    end else begin
      r_grf_we    <= w_we_n;
      r_grf_a3    <= w_a3_n;
      r_grf_wd    <= w_wd_n;
      r_grf_pc    <= w_pc_n;
      r_pend_mask <= 32'(w_mask_nxt);
`ifdef WB_TRACE_EN
      if (w_we_n) $display("%d@%h: $%d <= %h", $time, w_pc_n, w_a3_n, w_wd_n);
`endif
    end
  end

  assign io_wb.mdu_ready  = !w_full;
  assign io_wb.grf_we     = r_grf_we;
  assign io_wb.grf_a3     = r_grf_a3;
  assign io_wb.grf_wd     = r_grf_wd;
  assign io_wb.grf_pc     = r_grf_pc;
  assign io_wb.pend_mask  = r_pend_mask;
  assign io_wb.fifo_count = w_count;

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Scoreboard bench for grf_wb_arbiter: expected GRF writes are queued by the stimulus, a monitor checks them.
module tb_grf_wb_arbiter;
  import grf_wb_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  wb_req_t sb[$];

  grf_wb_arbiter_if #(.AW(5), .DW(32), .DEPTH(4)) wbi ();

  grf_wb_arbiter #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .io_wb (wbi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
    wb_req_t e;
    e.a3 = a3;
    e.wd = wd;
    e.pc = pc;
    sb.push_back(e);
  endtask

  // Monitor: every GRF write must match the oldest expected write.
  always @(negedge clk) begin
    if (reset && wbi.grf_we) begin
      wb_req_t act;
      wb_req_t e;
      act.a3 = wbi.grf_a3;
      act.wd = wbi.grf_wd;
      act.pc = wbi.grf_pc;
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got a3=%0d wd=%h pc=%h want no write", act.a3, act.wd, act.pc);
      end else begin
        e = sb.pop_front();
        if (act !== e) begin
          n_err++;
          $display("FAIL grf_write: got a3=%0d wd=%h pc=%h want a3=%0d wd=%h pc=%h",
                   act.a3, act.wd, act.pc, e.a3, e.wd, e.pc);
        end
      end
    end
  end

  initial begin
    wbi.pipe_we = 1'b0; wbi.pipe_a3 = '0; wbi.pipe_wd = '0; wbi.pipe_pc = '0;
    wbi.mdu_valid = 1'b0; wbi.mdu_a3 = '0; wbi.mdu_wd = '0; wbi.mdu_pc = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", 32'(wbi.grf_we), 32'd0);
    chk("rst_pend", wbi.pend_mask, 32'd0);
    chk("rst_count", 32'(wbi.fifo_count), 32'd0);
    reset = 1'b1;
    #1;
    chk("rst_ready", 32'(wbi.mdu_ready), 32'd1);

    // 1: single pipe write
    wbi.pipe_we = 1'b1; wbi.pipe_a3 = 5'd5; wbi.pipe_wd = 32'h1234; wbi.pipe_pc = 32'h3000;
    expect_wr(5'd5, 32'h1234, 32'h3000);
    tick();
    chk("t1_we", 32'(wbi.grf_we), 32'd1);
    wbi.pipe_we = 1'b0;
    tick();
    chk("t1_idle", 32'(wbi.grf_we), 32'd0);

    // 2: fill FIFO behind a continuous pipe stream, then drain in order
    wbi.pipe_we = 1'b1; wbi.pipe_a3 = 5'd1; wbi.pipe_wd = 32'h11; wbi.pipe_pc = 32'h100;
    wbi.mdu_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wbi.mdu_a3 = 5'(8 + k); wbi.mdu_wd = 32'h80 + 32'(k); wbi.mdu_pc = 32'h2000 + 32'(4 * k);
      expect_wr(5'd1, 32'h11, 32'h100);
      tick();
    end
    chk("t2_count_full", 32'(wbi.fifo_count), 32'd4);
    chk("t2_ready_full", 32'(wbi.mdu_ready), 32'd0);
    chk("t2_pend", wbi.pend_mask, 32'h0000_0F00);
    wbi.mdu_a3 = 5'd13; wbi.mdu_wd = 32'hBAD; wbi.mdu_pc = 32'hBAD;
    expect_wr(5'd1, 32'h11, 32'h100);
    tick();
    chk("t2_full_hold", 32'(wbi.fifo_count), 32'd4);
    chk("t2_pend_hold", wbi.pend_mask, 32'h0000_0F00);
    wbi.mdu_valid = 1'b0; wbi.pipe_we = 1'b0;
    for (int k = 0; k < 4; k++) expect_wr(5'(8 + k), 32'h80 + 32'(k), 32'h2000 + 32'(4 * k));
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t2_drain_count", 32'(wbi.fifo_count), 32'(3 - k));
    end
    chk("t2_ready_after", 32'(wbi.mdu_ready), 32'd1);
    chk("t2_pend_after", wbi.pend_mask, 32'd0);

    // 3: queued $9 killed by a younger pipe write to $9
    wbi.pipe_we = 1'b1; wbi.pipe_a3 = 5'd7; wbi.pipe_wd = 32'h77; wbi.pipe_pc = 32'h400;
    wbi.mdu_valid = 1'b1; wbi.mdu_a3 = 5'd9; wbi.mdu_wd = 32'hAA; wbi.mdu_pc = 32'h500;
    expect_wr(5'd7, 32'h77, 32'h400);
    tick();
    chk("t3_pend_live", wbi.pend_mask, 32'h0000_0200);
    wbi.mdu_valid = 1'b0;
    wbi.pipe_a3 = 5'd9; wbi.pipe_wd = 32'hBB; wbi.pipe_pc = 32'h404;
    expect_wr(5'd9, 32'hBB, 32'h404);
    tick();
    chk("t3_pend_killed", wbi.pend_mask, 32'd0);
    chk("t3_count_dead", 32'(wbi.fifo_count), 32'd1);
    wbi.pipe_we = 1'b0;
    tick();
    chk("t3_dead_pop_we", 32'(wbi.grf_we), 32'd0);
    chk("t3_count_empty", 32'(wbi.fifo_count), 32'd0);

    // 4: pipe write to $0 does not block a pop
    wbi.mdu_valid = 1'b1; wbi.mdu_a3 = 5'd12; wbi.mdu_wd = 32'hC0C0; wbi.mdu_pc = 32'h600;
    tick();
    chk("t4_pend", wbi.pend_mask, 32'h0000_1000);
    wbi.mdu_valid = 1'b0;
    wbi.pipe_we = 1'b1; wbi.pipe_a3 = 5'd0; wbi.pipe_wd = 32'hDEAD; wbi.pipe_pc = 32'h700;
    expect_wr(5'd12, 32'hC0C0, 32'h600);
    tick();
    chk("t4_count", 32'(wbi.fifo_count), 32'd0);
    wbi.pipe_we = 1'b0;

    // 5: MDU result to $0 accepted and dropped
    wbi.mdu_valid = 1'b1; wbi.mdu_a3 = 5'd0; wbi.mdu_wd = 32'h55; wbi.mdu_pc = 32'h800;
    #1;
    chk("t5_ready", 32'(wbi.mdu_ready), 32'd1);
    tick();
    wbi.mdu_valid = 1'b0;
    chk("t5_count", 32'(wbi.fifo_count), 32'd0);
    chk("t5_we", 32'(wbi.grf_we), 32'd0);
    tick();
    chk("t5_we2", 32'(wbi.grf_we), 32'd0);

    // 6: reset mid-drain drops every queued entry
    wbi.pipe_we = 1'b1; wbi.pipe_a3 = 5'd1; wbi.pipe_wd = 32'h22; wbi.pipe_pc = 32'h900;
    wbi.mdu_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wbi.mdu_a3 = 5'(2 + k); wbi.mdu_wd = 32'hE0 + 32'(k); wbi.mdu_pc = 32'hA00 + 32'(4 * k);
      expect_wr(5'd1, 32'h22, 32'h900);
      tick();
    end
    chk("t6_count3", 32'(wbi.fifo_count), 32'd3);
    chk("t6_pend3", wbi.pend_mask, 32'h0000_001C);
    wbi.pipe_we = 1'b0; wbi.mdu_valid = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("t6_rst_we", 32'(wbi.grf_we), 32'd0);
    chk("t6_rst_pend", wbi.pend_mask, 32'd0);
    chk("t6_rst_count", 32'(wbi.fifo_count), 32'd0);
    #1;
    reset = 1'b1;
    repeat (6) tick();
    chk("t6_post_count", 32'(wbi.fifo_count), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
